// File: rtl/fft_buf_pkg.sv
// fft_buf_pkg: shared definitions for the ping-pong FFT sample buffer.
//   - Default component width and address width.
//   - Complex word type {re, im}.
//   - Collision-policy constants for same-address dual writes.
//   - bitrev(): reverses the low w bits of an address (w <= BITREV_MAX_W).
package fft_buf_pkg;

  localparam int WIDTH_DEF    = 32;
  localparam int ADDR_W_DEF   = 6;
  localparam int BITREV_MAX_W = 16;

  // Which engine port's data lands when both ports write one address.
  localparam bit COLL_PORT_A = 1'b0;
  localparam bit COLL_PORT_B = 1'b1;

  typedef struct packed {
    logic signed [WIDTH_DEF-1:0] re;
    logic signed [WIDTH_DEF-1:0] im;
  } cplx_t;

  // Shifts the low w bits of a out LSB-first into r, so r ends up holding
  // them in reversed order; bits above w stay zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(
    input logic [BITREV_MAX_W-1:0] a,
    input int                      w
  );
    logic [BITREV_MAX_W-1:0] r;
    logic [BITREV_MAX_W-1:0] t;
    r = '0;
    t = a;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < w) begin
        r = {r[BITREV_MAX_W-2:0], t[0]};
        t = t >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_dual_bank.sv
// bram_dual_bank: one DEPTH x 2*WIDTH true dual-port RAM, read-first.
// Ports:
//   Clk, Rst        clock / async active-high reset (read registers only)
//   En              read enable; read registers hold when low
//   We_A/Addr_A/DI_A/DO_A   port A write enable, address, write data, read data
//   We_B/Addr_B/DI_B/DO_B   port B write enable, address, write data, read data
// Same-address dual write stores port B data when COLL_B_WINS=1, else port A.
module bram_dual_bank
  import fft_buf_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter bit COLL_B_WINS = COLL_PORT_B
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 En,
  input  logic                 We_A,
  input  logic [ADDR_W-1:0]    Addr_A,
  input  logic [2*WIDTH-1:0]   DI_A,
  output logic [2*WIDTH-1:0]   DO_A,
  input  logic                 We_B,
  input  logic [ADDR_W-1:0]    Addr_B,
  input  logic [2*WIDTH-1:0]   DI_B,
  output logic [2*WIDTH-1:0]   DO_B
);

  localparam int DEPTH = 2**ADDR_W;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic               same_addr;
  logic               wr_a_eff;
  logic               wr_b_eff;

  // On a same-address dual write only the winning port is allowed to land.
  assign same_addr = We_A && We_B && (Addr_A == Addr_B);
  assign wr_a_eff  = We_A && !(same_addr && (COLL_B_WINS == COLL_PORT_B));
  assign wr_b_eff  = We_B && !(same_addr && (COLL_B_WINS == COLL_PORT_A));

  always_ff @(posedge Clk) begin
    if (wr_a_eff) mem[Addr_A] <= DI_A;
    if (wr_b_eff) mem[Addr_B] <= DI_B;
  end

  // Reads sample the array before this edge's writes land: read-first.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      DO_A <= '0;
      DO_B <= '0;
    end else if (En) begin
      DO_A <= mem[Addr_A];
      DO_B <= mem[Addr_B];
    end
  end

endmodule

// File: rtl/fft_pingpong_bram.sv
// fft_pingpong_bram: double-buffered complex sample memory between the input
// stream and the in-place FFT engine.
// Ports:
//   Clk, Rst                       clock / async active-high reset
//   In_Valid, In_Ready, In_Data    stream side, fills bank wr_bank
//   Eng_Valid, Eng_Bank            engine owns a full bank, and which one
//   Eng_Done                       pulse: engine releases its bank
//   Eng_We_A/Addr_A/DI_A/DO_A      engine port A
//   Eng_We_B/Addr_B/DI_B/DO_B      engine port B
//   Wr_Count                       samples written into the current fill bank
module fft_pingpong_bram
  import fft_buf_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter bit BITREV      = 1'b1,
  parameter bit COLL_B_WINS = COLL_PORT_B
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [2*WIDTH-1:0]   In_Data,
  output logic                 Eng_Valid,
  output logic                 Eng_Bank,
  input  logic                 Eng_Done,
  input  logic                 Eng_We_A,
  input  logic [ADDR_W-1:0]    Eng_Addr_A,
  input  logic [2*WIDTH-1:0]   Eng_DI_A,
  output logic [2*WIDTH-1:0]   Eng_DO_A,
  input  logic                 Eng_We_B,
  input  logic [ADDR_W-1:0]    Eng_Addr_B,
  input  logic [2*WIDTH-1:0]   Eng_DI_B,
  output logic [2*WIDTH-1:0]   Eng_DO_B,
  output logic [ADDR_W:0]      Wr_Count
);

  localparam int DEPTH = 2**ADDR_W;

  logic [1:0]        full;
  logic              wr_bank;
  logic              rd_bank;
  logic              do_bank;
  logic [ADDR_W:0]   wr_cnt;
  logic              accept;
  logic              fill_last;
  logic              release_bank;
  logic [ADDR_W-1:0] fill_addr;

  logic [1:0]         eng_sel;
  logic [1:0]         bk_we_a;
  logic [1:0]         bk_we_b;
  logic [ADDR_W-1:0]  bk_addr_a [2];
  logic [2*WIDTH-1:0] bk_di_a   [2];
  logic [2*WIDTH-1:0] bk_do_a   [2];
  logic [2*WIDTH-1:0] bk_do_b   [2];

  assign In_Ready     = !full[wr_bank];
  assign accept       = In_Valid && In_Ready;
  assign fill_last    = (wr_cnt == (ADDR_W+1)'(DEPTH-1));
  assign Eng_Valid    = full[rd_bank];
  assign Eng_Bank     = rd_bank;
  assign release_bank = Eng_Done && Eng_Valid;
  assign Wr_Count     = wr_cnt;
  assign fill_addr    = BITREV ? ADDR_W'(bitrev(BITREV_MAX_W'(wr_cnt[ADDR_W-1:0]), ADDR_W))
                               : wr_cnt[ADDR_W-1:0];

  // The released bank is always full and the fill bank never is, so the two
  // full[] updates below always target different bits.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      do_bank <= 1'b0;
    end else begin
      if (accept) begin
        if (fill_last) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_cnt        <= '0;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (release_bank) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      // Remember which bank produced the last read so DO holds across release.
      if (Eng_Valid) do_bank <= rd_bank;
    end
  end

  // Each bank is driven either by the engine (when it owns it) or by the
  // stream through port A; ownership guarantees these never overlap.
  for (genvar g = 0; g < 2; g++) begin : g_bank
    assign eng_sel[g]   = Eng_Valid && (rd_bank == 1'(g));
    assign bk_we_a[g]   = eng_sel[g] ? Eng_We_A   : (accept && (wr_bank == 1'(g)));
    assign bk_addr_a[g] = eng_sel[g] ? Eng_Addr_A : fill_addr;
    assign bk_di_a[g]   = eng_sel[g] ? Eng_DI_A   : In_Data;
    assign bk_we_b[g]   = eng_sel[g] && Eng_We_B;

    bram_dual_bank #(
      .WIDTH       (WIDTH),
      .ADDR_W      (ADDR_W),
      .COLL_B_WINS (COLL_B_WINS)
    ) u_bank (
      .Clk    (Clk),
      .Rst    (Rst),
      .En     (eng_sel[g]),
      .We_A   (bk_we_a[g]),
      .Addr_A (bk_addr_a[g]),
      .DI_A   (bk_di_a[g]),
      .DO_A   (bk_do_a[g]),
      .We_B   (bk_we_b[g]),
      .Addr_B (Eng_Addr_B),
      .DI_B   (Eng_DI_B),
      .DO_B   (bk_do_b[g])
    );
  end

  assign Eng_DO_A = bk_do_a[do_bank];
  assign Eng_DO_B = bk_do_b[do_bank];

endmodule

// File: tb/tb_fft_pingpong_bram.sv
// Bench for fft_pingpong_bram: two instances (port-B-wins and port-A-wins)
// share all inputs; a behavioural model tracks memory contents, full-bank
// count, bank indices and read data.
module tb_fft_pingpong_bram;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        In_Valid = 1'b0;
  logic [63:0] In_Data = '0;
  logic        Eng_Done = 1'b0;
  logic        Eng_We_A = 1'b0;
  logic [5:0]  Eng_Addr_A = '0;
  logic [63:0] Eng_DI_A = '0;
  logic        Eng_We_B = 1'b0;
  logic [5:0]  Eng_Addr_B = '0;
  logic [63:0] Eng_DI_B = '0;

  logic [1:0]  in_ready;
  logic [1:0]  eng_valid;
  logic [1:0]  eng_bank;
  logic [63:0] do_a [2];
  logic [63:0] do_b [2];
  logic [6:0]  wr_count [2];

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fft_pingpong_bram #(
      .WIDTH(32), .ADDR_W(6), .BITREV(1'b1), .COLL_B_WINS(g == 0)
    ) dut (
      .Clk(Clk), .Rst(Rst),
      .In_Valid(In_Valid), .In_Ready(in_ready[g]), .In_Data(In_Data),
      .Eng_Valid(eng_valid[g]), .Eng_Bank(eng_bank[g]), .Eng_Done(Eng_Done),
      .Eng_We_A(Eng_We_A), .Eng_Addr_A(Eng_Addr_A), .Eng_DI_A(Eng_DI_A), .Eng_DO_A(do_a[g]),
      .Eng_We_B(Eng_We_B), .Eng_Addr_B(Eng_Addr_B), .Eng_DI_B(Eng_DI_B), .Eng_DO_B(do_b[g]),
      .Wr_Count(wr_count[g])
    );
  end

  // Reference model state
  logic [63:0] m_mem [2][2][64];   // [instance][bank][addr]
  logic [63:0] m_do_a [2];
  logic [63:0] m_do_b [2];
  int          n_full;             // banks filled and not yet released
  bit          m_wb, m_rb;
  int          m_cnt;
  logic [63:0] samp [64];

  int errors = 0;
  int checks = 0;

  function automatic int rev6(input int k);
    int r = 0;
    for (int i = 0; i < 6; i++) if (((k >> i) & 1) != 0) r += 1 << (5 - i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("in_ready",  64'(in_ready[i]),  64'(n_full < 2));
      chk("eng_valid", 64'(eng_valid[i]), 64'(n_full > 0));
      chk("eng_bank",  64'(eng_bank[i]),  64'(m_rb));
      chk("wr_count",  64'(wr_count[i]),  64'(m_cnt));
      chk("do_a",      do_a[i],           m_do_a[i]);
      chk("do_b",      do_b[i],           m_do_b[i]);
    end
  endtask

  task automatic model_reset();
    n_full = 0; m_wb = 0; m_rb = 0; m_cnt = 0;
    for (int i = 0; i < 2; i++) begin m_do_a[i] = '0; m_do_b[i] = '0; end
  endtask

  // One clock of stimulus: drive, advance the model at the edge, then check.
  task automatic cyc(input bit v, input logic [63:0] d, input bit done,
                     input bit wa, input int aa, input logic [63:0] da,
                     input bit wb, input int ab, input logic [63:0] db);
    bit valid0, acc;
    In_Valid = v; In_Data = d; Eng_Done = done;
    Eng_We_A = wa; Eng_Addr_A = 6'(aa); Eng_DI_A = da;
    Eng_We_B = wb; Eng_Addr_B = 6'(ab); Eng_DI_B = db;
    @(posedge Clk);
    valid0 = (n_full > 0);
    acc    = v && (n_full < 2);
    if (valid0) begin
      for (int i = 0; i < 2; i++) begin
        m_do_a[i] = m_mem[i][m_rb][aa];
        m_do_b[i] = m_mem[i][m_rb][ab];
        if (wa && wb && aa == ab) m_mem[i][m_rb][aa] = (i == 0) ? db : da;
        else begin
          if (wa) m_mem[i][m_rb][aa] = da;
          if (wb) m_mem[i][m_rb][ab] = db;
        end
      end
    end
    if (acc) begin
      for (int i = 0; i < 2; i++) m_mem[i][m_wb][rev6(m_cnt)] = d;
      m_cnt++;
      if (m_cnt == 64) begin m_cnt = 0; n_full++; m_wb = !m_wb; end
    end
    if (done && valid0) begin n_full--; m_rb = !m_rb; end
    #2;
    check_all();
    In_Valid = 0; Eng_Done = 0; Eng_We_A = 0; Eng_We_B = 0;
  endtask

  task automatic fill(input int n);
    for (int k = 0; k < n; k++) cyc(1, {$urandom, $urandom}, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_reads(input int n);
    for (int k = 0; k < n; k++)
      cyc(0, 0, 0, 0, $urandom_range(0, 63), 0, 0, $urandom_range(0, 63), 0);
  endtask

  initial begin
    logic [63:0] x, y, hold_a;
    // Reset
    #1 Rst = 1'b1;
    model_reset();
    repeat (2) @(posedge Clk);
    #2 Rst = 1'b0;
    #1 check_all();

    // Fill bank 0 with bit-reversed addressing
    for (int k = 0; k < 64; k++) begin
      samp[k] = {$urandom, $urandom};
      cyc(1, samp[k], 0, 0, 0, 0, 0, 0, 0);
    end
    chk("fill0_valid", 64'(eng_valid[0]), 64'd1);
    chk("fill0_bank",  64'(eng_bank[0]),  64'd0);
    chk("fill0_ready", 64'(in_ready[0]),  64'd1);
    cyc(0, 0, 0, 0, 1, 0, 0, 6, 0);
    chk("rd_addr1", do_a[0], samp[32]);
    chk("rd_addr6", do_b[0], samp[24]);

    // Read-first: write A and read B at the same address
    x = samp[40];
    y = {$urandom, $urandom};
    cyc(0, 0, 0, 1, 5, y, 0, 5, 0);
    chk("rf_do_a_old", do_a[0], x);
    chk("rf_do_b_old", do_b[0], x);
    cyc(0, 0, 0, 0, 5, 0, 0, 5, 0);
    chk("rf_reread", do_a[0], y);

    // Same-address collision
    cyc(0, 0, 0, 1, 9, 64'h11, 1, 9, 64'h22);
    cyc(0, 0, 0, 0, 9, 0, 0, 9, 0);
    chk("coll_b_wins", do_a[0], 64'h22);
    chk("coll_a_wins", do_a[1], 64'h11);

    // Random engine traffic in a small window to provoke collisions
    for (int k = 0; k < 30; k++)
      cyc(0, 0, 0, 1'($urandom), $urandom_range(0, 7), {$urandom, $urandom},
          1'($urandom), $urandom_range(0, 7), {$urandom, $urandom});

    // Back-pressure: fill bank 1 as well, then offer one more sample
    fill(64);
    chk("bp_ready", 64'(in_ready[0]), 64'd0);
    cyc(1, {$urandom, $urandom}, 0, 0, 0, 0, 0, 0, 0);
    chk("bp_no_accept", 64'(wr_count[0]), 64'd0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("bp_ready_after_done", 64'(in_ready[0]), 64'd1);
    chk("bp_bank_after_done",  64'(eng_bank[0]), 64'd1);
    rand_reads(8);

    // Last fill beat of bank 0 coincides with release of bank 1
    fill(63);
    cyc(1, {$urandom, $urandom}, 1, 0, 0, 0, 0, 0, 0);
    chk("sim_valid", 64'(eng_valid[0]), 64'd1);
    chk("sim_bank",  64'(eng_bank[0]),  64'd0);
    chk("sim_ready", 64'(in_ready[0]),  64'd1);
    chk("sim_cnt",   64'(wr_count[0]),  64'd0);
    rand_reads(6);

    // No bank owned: writes ignored, DO holds, Done ignored
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    hold_a = do_a[0];
    cyc(0, 0, 0, 1, 3, {$urandom, $urandom}, 0, 4, 0);
    chk("idle_do_hold", do_a[0], hold_a);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("idle_done_ignored", 64'(eng_bank[0]), 64'd1);

    // Async reset mid-fill at wr_cnt=37
    fill(64);
    rand_reads(2);
    fill(37);
    chk("pre_rst_cnt", 64'(wr_count[0]), 64'd37);
    #1 Rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      chk("arst_ready", 64'(in_ready[i]),  64'd1);
      chk("arst_cnt",   64'(wr_count[i]),  64'd0);
      chk("arst_valid", 64'(eng_valid[i]), 64'd0);
      chk("arst_do_a",  do_a[i], 64'd0);
      chk("arst_do_b",  do_b[i], 64'd0);
    end
    @(posedge Clk);
    #2 Rst = 1'b0;
    fill(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
